// File: rtl/core_pkg.sv
// Shared definitions for the pipelined core's register-file slice.
package core_pkg;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks pending destinations, flags RAW hazards,
// counts pending registers and latches write-backs to idle registers.
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter int unsigned BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  output logic          stall,
  output logic [AW:0]   busy_cnt,
  output logic          wb_err
);
  logic [NREGS-1:0] busy, busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             hz1, hz2;
  logic             wb_live;

  assign wb_live = wb_en && (wb_rd != AW'(REG_ZERO));

  // Clear before set so a same-cycle re-issue keeps ownership of the register.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)
      busy_nxt[wb_rd] = 1'b0;
    if (iss_en && (iss_rd != AW'(REG_ZERO)))
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end

  always_comb begin
    if (BYPASS != 0) begin
      hz1 = busy[rs1] && !(wb_en && (wb_rd == rs1));
      hz2 = busy[rs2] && !(wb_en && (wb_rd == rs2));
    end else begin
      hz1 = busy[rs1];
      hz2 = busy[rs2];
    end
    stall = rd_req && (hz1 || hz2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (wb_live && !busy[wb_rd])
        wb_err <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-first bypass, x0 hardwired
// to zero, registered read ports and an integrated RAW scoreboard.
module regfile_sb
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  localparam int unsigned AW    = $clog2(NREGS),
  parameter int unsigned BYPASS = 1,
  parameter int unsigned DBG_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            rdata_vld,
  output logic            stall,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     busy_cnt,
  output logic            wb_err,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rd1_val, rd2_val;
  logic            wb_live;

  assign wb_live = wb_en && (wb_rd != AW'(REG_ZERO));

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .BYPASS(BYPASS)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .rd_req  (rd_req),
    .rs1     (rs1),
    .rs2     (rs2),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .stall   (stall),
    .busy_cnt(busy_cnt),
    .wb_err  (wb_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rd1_val = regs[rs1];
    rd2_val = regs[rs2];
    if ((BYPASS != 0) && wb_live && (wb_rd == rs1))
      rd1_val = wb_data;
    if ((BYPASS != 0) && wb_live && (wb_rd == rs2))
      rd2_val = wb_data;
    if (rs1 == AW'(REG_ZERO))
      rd1_val = '0;
    if (rs2 == AW'(REG_ZERO))
      rd2_val = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata1    <= '0;
      rdata2    <= '0;
      rdata_vld <= 1'b0;
    end else if (rd_req && !stall) begin
      rdata1    <= rd1_val;
      rdata2    <= rd2_val;
      rdata_vld <= 1'b1;
    end else begin
      rdata_vld <= 1'b0;
    end
  end

  generate
    if (DBG_EN != 0) begin : g_dbg
      assign dbg_data = (dbg_addr == AW'(REG_ZERO)) ? '0 : regs[dbg_addr];
    end else begin : g_nodbg
      assign dbg_data = '0;
    end
  endgenerate
endmodule
